fetch_flow_controller: RTL and testbench
========================================

// Module: fetch_flow_controller
// PURPOSE
//  Owns the program counter and sequences the fetch/decode pipeline register.
//  Each cycle it decides whether the PC advances and whether the F/D register loads, holds or flushes.
//  It arbitrates between I-cache refill, load-use stall and branch/jump redirect.
//  Sits between the fetch adder/I-cache and the F/D register's en input; drives bubble and flush controls to F/D and D/E.
// PARAMETERS
//  DATA_WIDTH        32   PC/address width
//  RESET_PC          0    PC value loaded on reset
//  STALL_CNT_WIDTH   32   width of saturating stall-cycle counter
// PORTS
//  clk                 in   1           clock; all state updates on rising edge
//  rst                 in   1           synchronous, active-high reset
//  icache_hit_i        in   1           fetch at PC_o hit this cycle
//  icache_fill_done_i  in   1           refill complete (1-cycle pulse); ignored unless state==MISS
//  load_use_hazard_i   in   1           decode requests stall (load-use)
//  redirect_i          in   1           taken branch/jump resolved in execute
//  redirect_target_i   in   DATA_WIDTH  redirect destination
//  PCPlus4_i           in   DATA_WIDTH  PC_o+4 from fetch adder
//  PC_o                out  DATA_WIDTH  PC register
//  PCEn_o              out  1           PC_o updates at next edge
//  FDEn_o              out  1           F/D register load enable (0 = hold)
//  FDFlush_o           out  1           F/D register loads NOP/bubble
//  DEFlush_o           out  1           D/E register loads NOP/bubble
//  icache_fill_req_o   out  1           refill request, high for the whole MISS state
//  state_o             out  1           0=RUN, 1=MISS
//  stall_cycles_o      out  STALL_CNT_WIDTH  saturating count of cycles with PCEn_o==0
// BEHAVIOUR
//  State:
//   - FSM state RUN/MISS
//   - PC register
//   - pending_redirect flag plus pending_target register
//   - stall counter
//  Reset (rst high at edge):
//   - PC_o=RESET_PC, state=RUN, pending=0, stall_cycles_o=0
//   - while rst is high, combinational outputs are forced to PCEn_o=0, FDEn_o=0, FDFlush_o=1, DEFlush_o=1, fill_req=0
//  Reset mid-MISS: abandon the refill; fill_req drops the same cycle; pending is cleared.
//  RUN, priority redirect > miss > load-use:
//   - redirect_i: PCEn=1, PC<=redirect_target_i, FDEn=1, FDFlush=1, DEFlush=1; load_use and hit are ignored
//   - !icache_hit_i:
//     - next state MISS, PCEn=0
//     - if load_use: FDEn=0, FDFlush=0 (hold)
//     - else: FDEn=1, FDFlush=1 (bubble)
//   - load_use_hazard_i (hit): PCEn=0, FDEn=0, FDFlush=0, DEFlush=1 (bubble into execute)
//   - otherwise: PCEn=1, PC<=PCPlus4_i, FDEn=1, all flushes 0
//  MISS:
//   - fill_req=1, PCEn=0; F/D bubbles exactly as in RUN-miss (hold if load_use, else flush)
//   - redirect_i in MISS:
//     - set pending=1, pending_target<=redirect_target_i; a later redirect overwrites it
//     - FDFlush=1, DEFlush=1 that cycle
//   - icache_fill_done_i:
//     - next state RUN
//     - if pending (or redirect_i same cycle, which wins): PCEn=1, PC<=target, clear pending
//     - else PC held; fetch replays at PC_o the next cycle
//  Latency and counter:
//   - redirect to new PC_o: 1 cycle
//   - miss detect to fill_req: 1 cycle
//   - fill_done to first F/D load: 1 cycle
//   - stall_cycles_o increments when PCEn_o==0 and !rst; holds at all-ones (no wrap)
//  Widths: PC arithmetic is done upstream; no adder here. Targets are taken verbatim with no alignment check.
// TESTING
//  1 rst 2 cycles, release -> PC_o=0, state_o=0, stall_cycles_o=0, fill_req=0; FDFlush_o=1 while rst high.
//  2 hit=1, PCPlus4=PC+4, 3 cycles -> PC_o 0x4,0x8,0xC; FDEn_o=1, flushes 0 every cycle.
//  3 hit=0 at PC 0x10, fill_done 5 cycles later:
//    -> fill_req high 5 cycles, PC_o stays 0x10, FDFlush_o=1 throughout
//    -> RUN; PC_o=0x14 one cycle after the next hit
//  4 redirect_i=1 target 0x80 during MISS, then fill_done:
//    -> DEFlush_o=1 in the redirect cycle
//    -> PC_o=0x80 after fill_done; pending cleared
//  5 redirect_i and load_use_hazard_i same RUN cycle, target 0x40 -> PC_o=0x40, FDFlush_o=1, FDEn_o=1.
//  6 STALL_CNT_WIDTH=4, load_use held 20 cycles -> PC_o frozen, stall_cycles_o saturates at 0xF.

Source files
------------

// File: rtl/fetch_flow_controller.sv
// Fetch flow controller: owns the program counter and decides, every cycle,
// whether the PC advances and whether the F/D register loads, holds or
// flushes. Arbitrates I-cache refill, load-use stall and execute redirect.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RUN   | normal fetch; PC advances on hit unless stalled/redirected
//   MISS  | I-cache refill outstanding; PC frozen, redirects are parked
module fetch_flow_controller #(
    parameter int                    DATA_WIDTH      = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC        = '0,
    parameter int                    STALL_CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       icache_hit_i,
    input  logic                       icache_fill_done_i,
    input  logic                       load_use_hazard_i,
    input  logic                       redirect_i,
    input  logic [DATA_WIDTH-1:0]      redirect_target_i,
    input  logic [DATA_WIDTH-1:0]      PCPlus4_i,
    output logic [DATA_WIDTH-1:0]      PC_o,
    output logic                       PCEn_o,
    output logic                       FDEn_o,
    output logic                       FDFlush_o,
    output logic                       DEFlush_o,
    output logic                       icache_fill_req_o,
    output logic                       state_o,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles_o
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_MISS = 1'b1
    } state_t;

    localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX = '1;
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] pc_nxt;
    logic                  pending_q;
    logic                  pending_nxt;
    logic [DATA_WIDTH-1:0] pending_tgt_q;
    logic [DATA_WIDTH-1:0] pending_tgt_nxt;

    assign state_o = (state_q == ST_MISS);

    // State, PC and parked-redirect registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            PC_o          <= RESET_PC;
            pending_q     <= 1'b0;
            pending_tgt_q <= RESET_PC;
        end else begin
            state_q       <= state_nxt;
            PC_o          <= pc_nxt;
            pending_q     <= pending_nxt;
            pending_tgt_q <= pending_tgt_nxt;
        end
    end

    // Next-state and pipeline control decode.
    always_comb begin
        state_nxt         = state_q;
        pc_nxt            = PC_o;
        pending_nxt       = pending_q;
        pending_tgt_nxt   = pending_tgt_q;
        PCEn_o            = 1'b0;
        FDEn_o            = 1'b0;
        FDFlush_o         = 1'b0;
        DEFlush_o         = 1'b0;
        icache_fill_req_o = 1'b0;

        if (rst) begin
            // Everything downstream sees bubbles while reset is held.
            FDFlush_o = 1'b1;
            DEFlush_o = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (redirect_i) begin
                        PCEn_o    = 1'b1;
                        pc_nxt    = redirect_target_i;
                        FDEn_o    = 1'b1;
                        FDFlush_o = 1'b1;
                        DEFlush_o = 1'b1;
                    end else if (!icache_hit_i) begin
                        // Hold F/D if decode is stalled, otherwise bubble it.
                        state_nxt = ST_MISS;
                        FDEn_o    = !load_use_hazard_i;
                        FDFlush_o = !load_use_hazard_i;
                        DEFlush_o = load_use_hazard_i;
                    end else if (load_use_hazard_i) begin
                        DEFlush_o = 1'b1;
                    end else begin
                        PCEn_o = 1'b1;
                        pc_nxt = PCPlus4_i;
                        FDEn_o = 1'b1;
                    end
                end

                ST_MISS: begin
                    icache_fill_req_o = 1'b1;
                    FDEn_o            = !load_use_hazard_i;
                    FDFlush_o         = !load_use_hazard_i;
                    DEFlush_o         = load_use_hazard_i;

                    if (redirect_i) begin
                        // The wrong-path instructions in F/D and D/E are killed now;
                        // the new PC is applied once the refill completes.
                        FDEn_o    = 1'b1;
                        FDFlush_o = 1'b1;
                        DEFlush_o = 1'b1;
                        if (!icache_fill_done_i) begin
                            pending_nxt     = 1'b1;
                            pending_tgt_nxt = redirect_target_i;
                        end
                    end

                    if (icache_fill_done_i) begin
                        state_nxt   = ST_RUN;
                        pending_nxt = 1'b0;
                        if (redirect_i) begin
                            PCEn_o = 1'b1;
                            pc_nxt = redirect_target_i;
                        end else if (pending_q) begin
                            PCEn_o = 1'b1;
                            pc_nxt = pending_tgt_q;
                        end
                    end
                end

                default: begin
                    state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // Saturating count of cycles where the PC did not advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_o <= '0;
        end else if (!PCEn_o && (stall_cycles_o != STALL_MAX)) begin
            stall_cycles_o <= stall_cycles_o + STALL_ONE;
        end
    end

endmodule

// File: tb/tb_fetch_flow_controller.sv
// Bench for fetch_flow_controller: a table of per-cycle stimulus with
// hand-computed expected outputs, pushed to a queue on drive and popped
// when the outputs are sampled, plus a few hand-written sequences.
module tb_fetch_flow_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        hit;
    logic        fill_done;
    logic        lu;
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] pc_plus4;
    logic [31:0] pc;
    logic        pcen;
    logic        fden;
    logic        fdflush;
    logic        deflush;
    logic        fill_req;
    logic        st;
    logic [3:0]  stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Upstream fetch adder.
    assign pc_plus4 = pc + 32'd4;

    fetch_flow_controller #(
        .DATA_WIDTH     (32),
        .RESET_PC       (32'h0),
        .STALL_CNT_WIDTH(4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .icache_hit_i      (hit),
        .icache_fill_done_i(fill_done),
        .load_use_hazard_i (lu),
        .redirect_i        (redir),
        .redirect_target_i (tgt),
        .PCPlus4_i         (pc_plus4),
        .PC_o              (pc),
        .PCEn_o            (pcen),
        .FDEn_o            (fden),
        .FDFlush_o         (fdflush),
        .DEFlush_o         (deflush),
        .icache_fill_req_o (fill_req),
        .state_o           (st),
        .stall_cycles_o    (stall)
    );

    typedef struct {
        logic        rst;
        logic        hit;
        logic        done;
        logic        lu;
        logic        redir;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic        en;
        logic        fe;
        logic        ff;
        logic        df;
        logic        fr;
        logic        st;
        logic [3:0]  sc;
    } vec_t;

    vec_t        vecs[$];
    logic [41:0] exp_q[$];

    function automatic vec_t mk(input logic r, input logic h, input logic d,
                                input logic l, input logic x, input logic [31:0] t,
                                input logic [31:0] p, input logic en, input logic fe,
                                input logic ff, input logic df, input logic fr,
                                input logic s, input logic [3:0] sc);
        vec_t v;
        v.rst = r;  v.hit = h; v.done = d; v.lu = l; v.redir = x; v.tgt = t;
        v.pc  = p;  v.en  = en; v.fe = fe; v.ff = ff; v.df = df; v.fr = fr;
        v.st  = s;  v.sc  = sc;
        return v;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, compare mid-cycle.
    task automatic apply(input vec_t v, input string nm);
        logic [41:0] got;
        logic [41:0] want;
        @(posedge clk);
        #1;
        rst       = v.rst;
        hit       = v.hit;
        fill_done = v.done;
        lu        = v.lu;
        redir     = v.redir;
        tgt       = v.tgt;
        exp_q.push_back({v.pc, v.en, v.fe, v.ff, v.df, v.fr, v.st, v.sc});
        @(negedge clk);
        got  = {pc, pcen, fden, fdflush, deflush, fill_req, st, stall};
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got pc=%h en=%b fde=%b fdf=%b def=%b req=%b st=%b sc=%h  want pc=%h en=%b fde=%b fdf=%b def=%b req=%b st=%b sc=%h",
                     nm, got[41:10], got[9], got[8], got[7], got[6], got[5], got[4], got[3:0],
                     want[41:10], want[9], want[8], want[7], want[6], want[5], want[4], want[3:0]);
        end
    endtask

    initial begin
        int lat;
        bit seen;

        rst = 1'b1; hit = 1'b0; fill_done = 1'b0; lu = 1'b0; redir = 1'b0; tgt = '0;

        //              rst hit dn lu rd tgt          pc           en fe ff df fr st sc
        // reset
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,   32'h0,   0, 0, 1, 1, 0, 0, 4'd0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,   32'h0,   0, 0, 1, 1, 0, 0, 4'd0));
        // sequential hits
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,   32'h0,   1, 1, 0, 0, 0, 0, 4'd0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,   32'h4,   1, 1, 0, 0, 0, 0, 4'd0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,   32'h8,   1, 1, 0, 0, 0, 0, 4'd0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,   32'hC,   1, 1, 0, 0, 0, 0, 4'd0));
        // miss at 0x10, fill_done five cycles later
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h10,  0, 1, 1, 0, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h10,  0, 1, 1, 0, 1, 1, 4'd1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h10,  0, 1, 1, 0, 1, 1, 4'd2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h10,  0, 1, 1, 0, 1, 1, 4'd3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h10,  0, 1, 1, 0, 1, 1, 4'd4));
        vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0,   32'h10,  0, 1, 1, 0, 1, 1, 4'd5));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,   32'h10,  1, 1, 0, 0, 0, 0, 4'd6));
        // miss, redirect to 0x80 parked, applied at fill_done
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h14,  0, 1, 1, 0, 0, 0, 4'd6));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h80,  32'h14,  0, 1, 1, 1, 1, 1, 4'd7));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h14,  0, 1, 1, 0, 1, 1, 4'd8));
        vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0,   32'h14,  1, 1, 1, 0, 1, 1, 4'd9));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,   32'h80,  1, 1, 0, 0, 0, 0, 4'd9));
        // pending cleared: next refill without redirect holds PC
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h84,  0, 1, 1, 0, 0, 0, 4'd9));
        vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0,   32'h84,  0, 1, 1, 0, 1, 1, 4'd10));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,   32'h84,  1, 1, 0, 0, 0, 0, 4'd11));
        // redirect beats load-use, then redirect beats miss
        vecs.push_back(mk(0, 1, 0, 1, 1, 32'h40,  32'h88,  1, 1, 1, 1, 0, 0, 4'd11));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h100, 32'h40,  1, 1, 1, 1, 0, 0, 4'd11));
        // load-use stall, counter saturates
        vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,   32'h100, 0, 0, 0, 1, 0, 0, 4'd11));
        vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,   32'h100, 0, 0, 0, 1, 0, 0, 4'd12));
        vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,   32'h100, 0, 0, 0, 1, 0, 0, 4'd13));
        vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,   32'h100, 0, 0, 0, 1, 0, 0, 4'd14));
        vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,   32'h100, 0, 0, 0, 1, 0, 0, 4'd15));
        vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,   32'h100, 0, 0, 0, 1, 0, 0, 4'd15));
        vecs.push_back(mk(0, 1, 0, 1, 0, 32'h0,   32'h100, 0, 0, 0, 1, 0, 0, 4'd15));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,   32'h100, 1, 1, 0, 0, 0, 0, 4'd15));
        // miss with load-use holds F/D; redirect on the fill_done cycle wins
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h0,   32'h104, 0, 0, 0, 1, 0, 0, 4'd15));
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h0,   32'h104, 0, 0, 0, 1, 1, 1, 4'd15));
        vecs.push_back(mk(0, 0, 1, 0, 1, 32'h200, 32'h104, 1, 1, 1, 1, 1, 1, 4'd15));
        // reset mid-MISS with a parked redirect
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h200, 0, 1, 1, 0, 0, 0, 4'd15));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h300, 32'h200, 0, 1, 1, 1, 1, 1, 4'd15));
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,   32'h200, 0, 0, 1, 1, 0, 1, 4'd15));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,   32'h0,   0, 1, 1, 0, 0, 0, 4'd0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0,   32'h0,   0, 1, 1, 0, 1, 1, 4'd1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,   32'h0,   1, 1, 0, 0, 0, 0, 4'd2));
        // fill_done outside MISS is ignored
        vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,   32'h4,   1, 1, 0, 0, 0, 0, 4'd2));
        vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,   32'h8,   1, 1, 0, 0, 0, 0, 4'd2));

        @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("row%0d", i));
        end

        // Long load-use stall from reset: PC frozen, counter sticks at all-ones.
        apply(mk(1, 0, 0, 0, 0, 32'h0, 32'hC, 0, 0, 1, 1, 0, 0, 4'd2), "lu_rst0");
        apply(mk(1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1, 1, 0, 0, 4'd0), "lu_rst1");
        for (int i = 0; i < 20; i++) begin
            apply(mk(0, 1, 0, 1, 0, 32'h0, 32'h0, 0, 0, 0, 1, 0, 0,
                     (i > 15) ? 4'd15 : 4'(i)), $sformatf("lu_hold%0d", i));
        end

        // Miss detect to fill request latency.
        apply(mk(1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1, 1, 0, 0, 4'd15), "lat_rst0");
        apply(mk(1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1, 1, 0, 0, 4'd0), "lat_rst1");
        apply(mk(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 1, 0, 0, 0, 4'd0), "lat_miss");
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 4 && !seen; k++) begin
            @(posedge clk);
            #1;
            hit       = 1'b0;
            fill_done = 1'b0;
            @(negedge clk);
            if (fill_req) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        total++;
        if (!seen || lat != 1) begin
            bad++;
            $display("FAIL fill_req_latency: got seen=%0d lat=%0d want seen=1 lat=1", seen, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
